framebuffer: RTL and testbench

Pixel store for the CHIP-8 display, directly downstream of the `gpu` command engine. It holds the 64x32 monochrome image as 256 bytes, 32 rows x 8 bytes, MSB = leftmost pixel. It serves XOR-sprite-byte and clear requests from `gpu` through a valid/ready handshake and reports collisions back. A separate, independent read port serves display scanout.

---
 rtl/framebuffer_if.sv | 22 ++
 rtl/framebuffer.sv | 133 +++++++++++++
 tb/tb_framebuffer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/framebuffer_if.sv
// Request/response bundle between the gpu command engine (master) and the
// CHIP-8 framebuffer (slave).
interface framebuffer_if;
    logic       fb_req_valid;
    logic       fb_req_ready;
    logic       fb_req_op;
    logic [5:0] fb_req_x;
    logic [4:0] fb_req_y;
    logic [7:0] fb_req_data;
    logic       fb_done;
    logic       fb_collision;

    modport master (
        output fb_req_valid, fb_req_op, fb_req_x, fb_req_y, fb_req_data,
        input  fb_req_ready, fb_done, fb_collision
    );

    modport slave (
        input  fb_req_valid, fb_req_op, fb_req_x, fb_req_y, fb_req_data,
        output fb_req_ready, fb_done, fb_collision
    );
endinterface

// File: rtl/framebuffer.sv
// 64x32 monochrome CHIP-8 pixel store: XOR-sprite-byte and clear engine plus
// an independent registered scanout read port.
//
// state | meaning
// IDLE  | ready for a request
// RD0   | read first target byte
// WR0   | write first byte ^ mask0, start collision
// RD1   | read wrapped second byte (misaligned sprite only)
// WR1   | write second byte ^ mask1, accumulate collision
// CLR   | zero one byte per cycle, address 0..255
// DONE  | completion pulse, collision published
module framebuffer (
    input  logic         clk,
    input  logic         rst_n,
    framebuffer_if.slave fb,
    input  logic [7:0]   scan_addr,
    output logic [7:0]   scan_data
);
    typedef enum logic [2:0] {
        S_IDLE, S_RD0, S_WR0, S_RD1, S_WR1, S_CLR, S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  mem [256];
    logic [4:0]  y_q;
    logic [2:0]  b0_q;
    logic [2:0]  b1;
    logic        two_q;
    logic [7:0]  mask0_q, mask1_q;
    logic [7:0]  rd_q;
    logic [7:0]  clr_cnt;
    logic        coll_acc, coll_nxt;
    logic        accept;
    logic [15:0] mask_wide;
    logic        rd_en, we;
    logic [7:0]  rd_addr, wr_addr, wr_data;

    assign accept    = fb.fb_req_valid && (state == S_IDLE);
    // Upper byte = data >> s, lower byte = bits spilling into the next byte.
    assign mask_wide = {fb.fb_req_data, 8'h00} >> fb.fb_req_x[2:0];
    assign b1        = b0_q + 3'd1;

    assign fb.fb_req_ready = (state == S_IDLE);
    assign fb.fb_done      = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        rd_addr   = {y_q, b0_q};
        we        = 1'b0;
        wr_addr   = {y_q, b0_q};
        wr_data   = 8'h00;
        coll_nxt  = coll_acc;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = fb.fb_req_op ? S_CLR : S_RD0;
            end
            S_RD0: begin
                rd_en     = 1'b1;
                state_nxt = S_WR0;
            end
            S_WR0: begin
                we        = 1'b1;
                wr_data   = rd_q ^ mask0_q;
                coll_nxt  = |(rd_q & mask0_q);
                state_nxt = two_q ? S_RD1 : S_DONE;
            end
            S_RD1: begin
                rd_en     = 1'b1;
                rd_addr   = {y_q, b1};
                state_nxt = S_WR1;
            end
            S_WR1: begin
                we        = 1'b1;
                wr_addr   = {y_q, b1};
                wr_data   = rd_q ^ mask1_q;
                coll_nxt  = coll_acc | (|(rd_q & mask1_q));
                state_nxt = S_DONE;
            end
            S_CLR: begin
                we        = 1'b1;
                wr_addr   = clr_cnt;
                wr_data   = 8'h00;
                coll_nxt  = 1'b0;
                if (clr_cnt == 8'hFF) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Storage is deliberately not reset; the gpu clears it at boot.
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
        if (rd_en) rd_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            y_q             <= '0;
            b0_q            <= '0;
            two_q           <= 1'b0;
            mask0_q         <= '0;
            mask1_q         <= '0;
            clr_cnt         <= '0;
            coll_acc        <= 1'b0;
            fb.fb_collision <= 1'b0;
            scan_data       <= 8'h00;
        end else begin
            state     <= state_nxt;
            coll_acc  <= coll_nxt;
            // Nonblocking read alongside the write gives old data on a hit.
            scan_data <= mem[scan_addr];
            if (accept) begin
                y_q             <= fb.fb_req_y;
                b0_q            <= fb.fb_req_x[5:3];
                two_q           <= (fb.fb_req_x[2:0] != 3'd0);
                mask0_q         <= mask_wide[15:8];
                mask1_q         <= mask_wide[7:0];
                clr_cnt         <= 8'h00;
                fb.fb_collision <= 1'b0;
            end else begin
                if (state == S_CLR) clr_cnt <= clr_cnt + 8'd1;
                if (state_nxt == S_DONE) fb.fb_collision <= coll_nxt;
            end
        end
    end
endmodule

// File: tb/tb_framebuffer.sv
// Randomized and directed checks of framebuffer against a pixel-level model.
module tb_framebuffer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] scan_addr;
    logic [7:0] scan_data;
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] ref_mem [256];
    logic [7:0] scan_at_done, scan_after_done;

    framebuffer_if fb_bus ();

    framebuffer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fb        (fb_bus.slave),
        .scan_addr (scan_addr),
        .scan_data (scan_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pixel-level model: each set sprite bit toggles pixel (x+i) mod 64 of row y.
    function automatic logic model_xor(int x, int y, logic [7:0] d);
        logic c;
        c = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (d[7-i]) begin
                int col;
                int a;
                int bp;
                col = (x + i) % 64;
                a   = y * 8 + col / 8;
                bp  = 7 - (col % 8);
                if (ref_mem[a][bp]) c = 1'b1;
                ref_mem[a][bp] = ~ref_mem[a][bp];
            end
        end
        return c;
    endfunction

    function automatic void model_clear();
        for (int a = 0; a < 256; a++) ref_mem[a] = 8'h00;
    endfunction

    task automatic do_req(input string tag, input logic op, input logic [5:0] x,
                          input logic [4:0] y, input logic [7:0] d,
                          input int exp_lat, input logic exp_coll);
        int guard;
        int lat;
        @(negedge clk);
        fb_bus.fb_req_valid = 1'b1;
        fb_bus.fb_req_op    = op;
        fb_bus.fb_req_x     = x;
        fb_bus.fb_req_y     = y;
        fb_bus.fb_req_data  = d;
        guard = 0;
        while (!fb_bus.fb_req_ready && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 600) begin
            chk({tag, "_ready_timeout"}, guard, 0);
            fb_bus.fb_req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        fb_bus.fb_req_valid = 1'b0;
        lat = 1;
        chk({tag, "_coll_cleared"}, fb_bus.fb_collision, 1'b0);
        while (!fb_bus.fb_done && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_collision"}, fb_bus.fb_collision, exp_coll);
        scan_at_done = scan_data;
        @(negedge clk);
        scan_after_done = scan_data;
        chk({tag, "_done_pulse"}, fb_bus.fb_done, 1'b0);
        chk({tag, "_coll_hold"}, fb_bus.fb_collision, exp_coll);
        chk({tag, "_ready_again"}, fb_bus.fb_req_ready, 1'b1);
    endtask

    task automatic req_xor(input string tag, input int x, input int y, input logic [7:0] d);
        logic c;
        c = model_xor(x, y, d);
        do_req(tag, 1'b0, 6'(x), 5'(y), d, (x % 8 == 0) ? 3 : 5, c);
    endtask

    task automatic req_clear(input string tag);
        model_clear();
        do_req(tag, 1'b1, 6'd0, 5'd0, 8'h00, 257, 1'b0);
    endtask

    task automatic scan_byte(input string tag, input int a, input logic [7:0] exp);
        @(negedge clk);
        scan_addr = 8'(a);
        @(negedge clk);
        chk(tag, scan_data, exp);
    endtask

    task automatic scan_range(input string tag, input int lo, input int hi);
        @(negedge clk);
        scan_addr = 8'(lo);
        for (int a = lo; a <= hi; a++) begin
            @(negedge clk);
            chk($sformatf("%s_%0d", tag, a), scan_data, ref_mem[a]);
            scan_addr = 8'(a + 1);
        end
    endtask

    initial begin
        int n;
        int done_seen;
        rst_n               = 1'b0;
        scan_addr           = 8'h00;
        fb_bus.fb_req_valid = 1'b0;
        fb_bus.fb_req_op    = 1'b0;
        fb_bus.fb_req_x     = '0;
        fb_bus.fb_req_y     = '0;
        fb_bus.fb_req_data  = '0;
        model_clear();

        @(negedge clk);
        @(negedge clk);
        chk("rst_scan_data", scan_data, 8'h00);
        chk("rst_done", fb_bus.fb_done, 1'b0);
        chk("rst_coll", fb_bus.fb_collision, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", fb_bus.fb_req_ready, 1'b1);

        req_clear("clr0");
        scan_range("clr0_scan", 0, 255);

        req_xor("x8a", 8, 0, 8'hF0);
        scan_byte("x8a_addr1", 1, 8'hF0);
        scan_addr = 8'd1;
        req_xor("x8b", 8, 0, 8'hF0);
        chk("rbw_old", scan_at_done, 8'hF0);
        chk("rbw_new", scan_after_done, 8'h00);
        scan_byte("x8b_addr1", 1, 8'h00);

        req_clear("clr1");
        req_xor("x3", 3, 2, 8'hFF);
        scan_byte("x3_addr16", 16, 8'h1F);
        scan_byte("x3_addr17", 17, 8'hE0);

        req_clear("clr2");
        req_xor("wrap_a", 61, 31, 8'hFF);
        scan_byte("wrap_255", 255, 8'h07);
        scan_byte("wrap_248", 248, 8'hF8);
        scan_range("wrap_row", 248, 255);
        req_xor("wrap_b", 0, 31, 8'h80);
        scan_byte("wrap_248b", 248, 8'h78);

        // Interrupt a clear at c100 on an already-zero buffer.
        req_clear("clr3");
        @(negedge clk);
        fb_bus.fb_req_valid = 1'b1;
        fb_bus.fb_req_op    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fb_bus.fb_req_valid = 1'b0;
        done_seen = 0;
        n = 1;
        while (n < 100) begin
            if (fb_bus.fb_done) done_seen++;
            @(negedge clk);
            n++;
        end
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (fb_bus.fb_done) done_seen++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (fb_bus.fb_done) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);
        chk("abort_ready", fb_bus.fb_req_ready, 1'b1);
        chk("abort_coll", fb_bus.fb_collision, 1'b0);
        req_xor("abort_xor", 20, 5, 8'hA5);
        scan_range("abort_scan", 42, 43);

        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                req_clear($sformatf("rclr%0d", t));
            end else begin
                int x;
                int y;
                logic [7:0] d;
                x = $urandom_range(0, 63);
                y = $urandom_range(0, 31);
                d = 8'($urandom);
                req_xor($sformatf("rx%0d", t), x, y, d);
                scan_byte($sformatf("rx%0d_b0", t), y * 8 + x / 8, ref_mem[y * 8 + x / 8]);
                scan_byte($sformatf("rx%0d_b1", t), y * 8 + ((x / 8 + 1) % 8),
                          ref_mem[y * 8 + ((x / 8 + 1) % 8)]);
            end
        end
        scan_range("final", 0, 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
